// File: rtl/seq_mult_param.sv
// Multi-cycle WIDTH x WIDTH multiplier built from DIGIT x DIGIT partial products, one per clock.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port and two's-complement operation.
`timescale 1ns/1ps
module seq_mult_param #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic               signed_mode,
`endif
   output logic [2*WIDTH-1:0] product,
   output logic               done,
   output logic               busy
);

   localparam int K  = WIDTH / DIGIT;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
`ifdef SEQ_MULT_SIGNED_EN
      S_NEG  = 2'd2,
`endif
      S_DONE = 2'd3
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [PW-1:0]     acc_q;
   logic [PW-1:0]     acc_d;
   logic [IW-1:0]     i_q;
   logic [IW-1:0]     j_q;
   logic [PW-1:0]     product_q;
   logic              done_q;
   logic              busy_q;
   logic [DIGIT-1:0]  a_dig_s;
   logic [DIGIT-1:0]  b_dig_s;
   logic [2*DIGIT-1:0] pp_s;
   logic [31:0]       shamt_s;
   logic [WIDTH-1:0]  a_mag_s;
   logic [WIDTH-1:0]  b_mag_s;
   logic              last_s;
`ifdef SEQ_MULT_SIGNED_EN
   logic              neg_q;
   logic              neg_s;
`endif

   // Operand magnitudes at capture and the next accumulator value for the current digit pair
   always_comb begin
      a_dig_s = DIGIT'(a_q >> (32'(DIGIT) * 32'(i_q)));
      b_dig_s = DIGIT'(b_q >> (32'(DIGIT) * 32'(j_q)));
      pp_s    = {{DIGIT{1'b0}}, a_dig_s} * {{DIGIT{1'b0}}, b_dig_s};
      shamt_s = 32'(DIGIT) * (32'(i_q) + 32'(j_q));
      acc_d   = acc_q + (PW'(pp_s) << shamt_s);
      last_s  = (i_q == IW'(K - 1)) && (j_q == IW'(K - 1));
`ifdef SEQ_MULT_SIGNED_EN
      // -2^(WIDTH-1) negates to itself, which is already its correct unsigned magnitude
      a_mag_s = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1'b1)) : a;
      b_mag_s = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1'b1)) : b;
      neg_s   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
      a_mag_s = a;
      b_mag_s = b;
`endif
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         i_q       <= '0;
         j_q       <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
         neg_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a_mag_s;
                  b_q     <= b_mag_s;
                  acc_q   <= '0;
                  i_q     <= '0;
                  j_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_MAC;
`ifdef SEQ_MULT_SIGNED_EN
                  neg_q   <= neg_s;
`endif
               end
            end
            S_MAC: begin
               acc_q <= acc_d;
               if (j_q == IW'(K - 1)) begin
                  j_q <= '0;
                  i_q <= last_s ? '0 : (i_q + IW'(1'b1));
               end else begin
                  j_q <= j_q + IW'(1'b1);
               end
               if (last_s) begin
`ifdef SEQ_MULT_SIGNED_EN
                  if (neg_q) begin
                     state_q <= S_NEG;
                  end else begin
                     product_q <= acc_d;
                     done_q    <= 1'b1;
                     state_q   <= S_DONE;
                  end
`else
                  product_q <= acc_d;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
`endif
               end
            end
`ifdef SEQ_MULT_SIGNED_EN
            S_NEG: begin
               acc_q     <= ~acc_q + PW'(1'b1);
               product_q <= ~acc_q + PW'(1'b1);
               done_q    <= 1'b1;
               state_q   <= S_DONE;
            end
`endif
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign product = product_q;
   assign done    = done_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed and table-driven bench for seq_mult_param at 16/4, 8/4 and 12/3 configurations.
`timescale 1ns/1ps
module tb_seq_mult_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start16, d16, bz16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic        start8, d8, bz8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        start12, d12, bz12;
   logic [11:0] a12, b12;
   logic [23:0] p12;
`ifdef SEQ_MULT_SIGNED_EN
   logic        sm16;
`endif

   int errors = 0;
   int checks = 0;

   seq_mult_param #(.WIDTH(16), .DIGIT(4)) u16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
`ifdef SEQ_MULT_SIGNED_EN
      .signed_mode(sm16),
`endif
      .product(p16), .done(d16), .busy(bz16));

   seq_mult_param #(.WIDTH(8), .DIGIT(4)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef SEQ_MULT_SIGNED_EN
      .signed_mode(1'b0),
`endif
      .product(p8), .done(d8), .busy(bz8));

   seq_mult_param #(.WIDTH(12), .DIGIT(3)) u12 (
      .clk(clk), .rst(rst), .start(start12), .a(a12), .b(b12),
`ifdef SEQ_MULT_SIGNED_EN
      .signed_mode(1'b0),
`endif
      .product(p12), .done(d12), .busy(bz12));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sm;
      logic [31:0] p;
      int          lat;
      string       nm;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                        input logic [31:0] ep, input int el, input string nm);
      int          done_at, done_cnt, busy_cnt;
      logic [31:0] p_at;
      done_at = 0; done_cnt = 0; busy_cnt = 0; p_at = '0;
      @(negedge clk);
      a16 = av; b16 = bv; start16 = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
      sm16 = sm;
`endif
      @(posedge clk);
      #1;
      start16 = 1'b0; a16 = ~av; b16 = bv ^ 16'h5A5A;
      for (int c = 1; c <= el + 4; c++) begin
         @(negedge clk);
         if (bz16) busy_cnt++;
         if (d16) begin
            done_cnt++;
            if (done_at == 0) begin
               done_at = c;
               p_at    = p16;
            end
         end
      end
      chk({nm, " product"}, 64'(p_at), 64'(ep));
      chk({nm, " latency"}, 64'(done_at), 64'(el));
      chk({nm, " done pulses"}, 64'(done_cnt), 64'd1);
      chk({nm, " busy cycles"}, 64'(busy_cnt), 64'(el));
      chk({nm, " product held"}, 64'(p16), 64'(ep));
   endtask

   task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ep);
      int done_at;
      logic [15:0] p_at;
      done_at = 0; p_at = '0;
      @(negedge clk);
      a8 = av; b8 = bv; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (d8 && done_at == 0) begin
            done_at = c;
            p_at    = p8;
         end
      end
      chk("w8 product", 64'(p_at), 64'(ep));
      chk("w8 latency", 64'(done_at), 64'd5);
   endtask

   task automatic run12(input logic [11:0] av, input logic [11:0] bv);
      int done_at;
      logic [23:0] p_at, ep;
      done_at = 0; p_at = '0;
      ep = {12'd0, av} * {12'd0, bv};
      @(negedge clk);
      a12 = av; b12 = bv; start12 = 1'b1;
      @(posedge clk);
      #1 start12 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (d12 && done_at == 0) begin
            done_at = c;
            p_at    = p12;
         end
      end
      chk("w12 product", 64'(p_at), 64'(ep));
      chk("w12 latency", 64'(done_at), 64'd17);
   endtask

   initial begin
      int          done_at, done_cnt, done_at2;
      logic [31:0] p_at, p_at2;

      vq.push_back('{16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 17, "u 1234x5678"});
      vq.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 17, "u FFFFxFFFF"});
      vq.push_back('{16'h0000, 16'hABCD, 1'b0, 32'h0000_0000, 17, "u 0xABCD"});
      vq.push_back('{16'h0001, 16'hFFFF, 1'b0, 32'h0000_FFFF, 17, "u 1xFFFF"});
      vq.push_back('{16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 17, "u 8000x8000"});
      vq.push_back('{16'hFFFE, 16'h0003, 1'b0, 32'h0002_FFFA, 17, "u FFFEx3"});
      vq.push_back('{16'h00FF, 16'h0100, 1'b0, 32'h0000_FF00, 17, "u 00FFx0100"});
`ifdef SEQ_MULT_SIGNED_EN
      vq.push_back('{16'hFFFE, 16'h0003, 1'b1, 32'hFFFF_FFFA, 18, "s -2x3"});
      vq.push_back('{16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 17, "s min x min"});
      vq.push_back('{16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, 18, "s min x 1"});
      vq.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 17, "s -1x-1"});
      vq.push_back('{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 18, "s max x min"});
      sm16 = 1'b0;
`endif

      rst = 1'b1;
      start16 = 1'b0; a16 = '0; b16 = '0;
      start8  = 1'b0; a8  = '0; b8  = '0;
      start12 = 1'b0; a12 = '0; b12 = '0;
      #12;
      chk("reset product", 64'(p16), 64'd0);
      chk("reset done", 64'(d16), 64'd0);
      chk("reset busy", 64'(bz16), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vq[k]) run16(vq[k].a, vq[k].b, vq[k].sm, vq[k].p, vq[k].lat, vq[k].nm);

      // start re-pulsed with other operands during MAC must be ignored
      done_at = 0; done_cnt = 0; p_at = '0;
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h5678; start16 = 1'b1;
      @(posedge clk);
      #1 start16 = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (d16) begin
            done_cnt++;
            if (done_at == 0) begin done_at = c; p_at = p16; end
         end
         if (c == 3 || c == 10) begin
            start16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222;
         end else begin
            start16 = 1'b0;
         end
      end
      chk("ignored start product", 64'(p_at), 64'h0626_0060);
      chk("ignored start latency", 64'(done_at), 64'd17);
      chk("ignored start pulses", 64'(done_cnt), 64'd1);

      // start held high restarts right after the done cycle
      done_at = 0; done_at2 = 0; p_at = '0; p_at2 = '0;
      @(negedge clk);
      a16 = 16'd3; b16 = 16'd5; start16 = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (d16) begin
            if (done_at == 0) begin done_at = c; p_at = p16; end
            else if (done_at2 == 0) begin done_at2 = c; p_at2 = p16; end
         end
         if (c == 18) chk("held start idle busy", 64'(bz16), 64'd0);
         if (c == 5) begin a16 = 16'd7; b16 = 16'd9; end
         if (c == 20) start16 = 1'b0;
      end
      chk("held first product", 64'(p_at), 64'd15);
      chk("held first latency", 64'(done_at), 64'd17);
      chk("held second product", 64'(p_at2), 64'd63);
      chk("held second latency", 64'(done_at2), 64'd35);
      chk("held final busy", 64'(bz16), 64'd0);

      // asynchronous reset in the middle of MAC
      @(negedge clk);
      a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
      @(posedge clk);
      #1 start16 = 1'b0;
      repeat (8) @(negedge clk);
      chk("pre-reset busy", 64'(bz16), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async reset product", 64'(p16), 64'd0);
      chk("async reset done", 64'(d16), 64'd0);
      chk("async reset busy", 64'(bz16), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run16(16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 17, "after reset");

      run8(8'hC8, 8'h64, 16'h4E20);
      run8(8'hFF, 8'hFF, 16'hFE01);

      run12(12'hFFF, 12'hFFF);
      run12(12'h000, 12'h5A5);
      for (int n = 0; n < 1000; n++) run12(12'($urandom), 12'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
